// File: rtl/tfe_pkg.sv
`default_nettype none
// ============================================================================
// Package     : tfe_pkg
// Description : Shared types and constants for the TFE stimulus generator
//               and its LFSR: default widths, flow-ID mode codes, FSM state
//               encoding and the Galois LFSR polynomial with its step function.
// Revision    : 1.0 - initial release
// ============================================================================
package tfe_pkg;

  localparam int TUPLE_W_DEF = 104;
  localparam int FEAT_W_DEF  = 256;

  // Flow-ID generation modes
  localparam logic [1:0] MODE_SEQ   = 2'd0;
  localparam logic [1:0] MODE_WRAP  = 2'd1;
  localparam logic [1:0] MODE_LFSR  = 2'd2;
  localparam logic [1:0] MODE_CONST = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // x^32 + x^22 + x^2 + x + 1, right-shifting Galois form
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return {1'b0, s[31:1]} ^ (s[0] ? LFSR_TAPS : 32'h0000_0000);
  endfunction

endpackage
`default_nettype wire

// File: rtl/tfe_lfsr.sv
`default_nettype none
// ============================================================================
// Module      : tfe_lfsr
// Description : 32-bit Galois LFSR with synchronous seed load and advance
//               enable. Load has priority over advance.
// Ports       : clk, rst     - clock, synchronous active-high reset (-> SEED)
//               i_load       - reload SEED next cycle
//               i_adv        - step the register one position
//               o_state      - current register contents
// Revision    : 1.0 - initial release
// ============================================================================
module tfe_lfsr
  import tfe_pkg::*;
#(
  parameter logic [31:0] SEED = 32'hACE1_2468
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_load,
  input  logic        i_adv,
  output logic [31:0] o_state
);

  logic [31:0] state_q;
  logic [31:0] state_d;

  always_comb begin
    state_d = state_q;
    if (i_load) begin
      state_d = SEED;
    end else if (i_adv) begin
      state_d = lfsr_next(state_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign o_state = state_q;

endmodule
`default_nettype wire

// File: rtl/tfe_stim_gen.sv
`default_nettype none
// ============================================================================
// Module      : tfe_stim_gen
// Description : Packet-stimulus generator for the hash TFE. Emits a programmed
//               number of bursts of 5-tuple/feature packets separated by idle
//               gaps, honouring downstream valid/ready backpressure.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               cfg_start/cfg_abort - run control (abort has priority)
//               cfg_*               - run configuration, latched on start
//               o_tuple/o_raw_feature/o_valid, i_ready - packet stream
//               o_busy, o_done, o_pkt_cnt             - run status
// Revision    : 1.0 - initial release
// ============================================================================
module tfe_stim_gen
  import tfe_pkg::*;
#(
  parameter int          TUPLE_W   = TUPLE_W_DEF,
  parameter int          FEAT_W    = FEAT_W_DEF,
  parameter int          CNT_W     = 16,
  parameter logic [31:0] LFSR_SEED = 32'hACE1_2468
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_start,
  input  logic                 cfg_abort,
  input  logic [1:0]           cfg_mode,
  input  logic [7:0]           cfg_num_bursts,
  input  logic [CNT_W-1:0]     cfg_burst_len,
  input  logic [CNT_W-1:0]     cfg_gap_len,
  input  logic [CNT_W-1:0]     cfg_flow_mod,
  input  logic [TUPLE_W-1:0]   cfg_flow_base,
  input  logic [FEAT_W-1:0]    cfg_feature,
  output logic [TUPLE_W-1:0]   o_tuple,
  output logic [FEAT_W-1:0]    o_raw_feature,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [CNT_W+8-1:0]   o_pkt_cnt
);

  localparam int PC_W = CNT_W + 8;

  state_e               state_q,   state_d;
  logic [1:0]           mode_q,    mode_d;
  logic [7:0]           nb_q,      nb_d;
  logic [CNT_W-1:0]     bl_q,      bl_d;
  logic [CNT_W-1:0]     gl_q,      gl_d;
  logic [CNT_W-1:0]     fm_q,      fm_d;
  logic [TUPLE_W-1:0]   base_q,    base_d;
  logic [FEAT_W-1:0]    feat_q,    feat_d;
  logic [PC_W-1:0]      pkt_cnt_q, pkt_cnt_d;
  logic [CNT_W-1:0]     idx_q,     idx_d;
  logic [7:0]           burst_q,   burst_d;
  logic [CNT_W-1:0]     gap_cnt_q, gap_cnt_d;
  logic [CNT_W-1:0]     wrap_q,    wrap_d;
  logic                 done_q,    done_d;

  logic                 lfsr_load;
  logic                 lfsr_adv;
  logic [31:0]          lfsr_state;

  logic [CNT_W-1:0]     idx_inc;
  logic [CNT_W-1:0]     wrap_inc;
  logic [7:0]           burst_inc;
  logic [TUPLE_W-1:0]   tuple_off;

  tfe_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .i_load  (lfsr_load),
    .i_adv   (lfsr_adv),
    .o_state (lfsr_state)
  );

  assign idx_inc   = idx_q + CNT_W'(1);
  assign wrap_inc  = wrap_q + CNT_W'(1);
  assign burst_inc = burst_q + 8'd1;

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    nb_d      = nb_q;
    bl_d      = bl_q;
    gl_d      = gl_q;
    fm_d      = fm_q;
    base_d    = base_q;
    feat_d    = feat_q;
    pkt_cnt_d = pkt_cnt_q;
    idx_d     = idx_q;
    burst_d   = burst_q;
    gap_cnt_d = gap_cnt_q;
    wrap_d    = wrap_q;
    done_d    = 1'b0;
    lfsr_load = 1'b0;
    lfsr_adv  = 1'b0;

    if (cfg_abort) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (cfg_start) begin
            mode_d    = cfg_mode;
            nb_d      = cfg_num_bursts;
            bl_d      = cfg_burst_len;
            gl_d      = cfg_gap_len;
            // A zero modulus behaves as a single flow
            fm_d      = (cfg_flow_mod == '0) ? CNT_W'(1) : cfg_flow_mod;
            base_d    = cfg_flow_base;
            feat_d    = cfg_feature;
            pkt_cnt_d = '0;
            idx_d     = '0;
            burst_d   = '0;
            gap_cnt_d = '0;
            wrap_d    = '0;
            lfsr_load = 1'b1;
            if ((cfg_num_bursts == 8'd0) || (cfg_burst_len == '0)) begin
              state_d = ST_DONE;
            end else begin
              state_d = ST_SEND;
            end
          end
        end

        ST_SEND: begin
          if (i_ready) begin
            pkt_cnt_d = pkt_cnt_q + PC_W'(1);
            lfsr_adv  = 1'b1;
            wrap_d    = (wrap_inc == fm_q) ? '0 : wrap_inc;
            if (idx_inc == bl_q) begin
              burst_d = burst_inc;
              idx_d   = '0;
              if (burst_inc == nb_q) begin
                state_d = ST_DONE;
              end else if (gl_q != '0) begin
                gap_cnt_d = '0;
                state_d   = ST_GAP;
              end
            end else begin
              idx_d = idx_inc;
            end
          end
        end

        ST_GAP: begin
          // Only entered with a nonzero gap length
          if (gap_cnt_q == (gl_q - CNT_W'(1))) begin
            gap_cnt_d = '0;
            idx_d     = '0;
            state_d   = ST_SEND;
          end else begin
            gap_cnt_d = gap_cnt_q + CNT_W'(1);
          end
        end

        ST_DONE: begin
          // Completion pulse lands in the first IDLE cycle, when busy is low
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end

        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      mode_q    <= MODE_SEQ;
      nb_q      <= '0;
      bl_q      <= '0;
      gl_q      <= '0;
      fm_q      <= CNT_W'(1);
      base_q    <= '0;
      feat_q    <= '0;
      pkt_cnt_q <= '0;
      idx_q     <= '0;
      burst_q   <= '0;
      gap_cnt_q <= '0;
      wrap_q    <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      nb_q      <= nb_d;
      bl_q      <= bl_d;
      gl_q      <= gl_d;
      fm_q      <= fm_d;
      base_q    <= base_d;
      feat_q    <= feat_d;
      pkt_cnt_q <= pkt_cnt_d;
      idx_q     <= idx_d;
      burst_q   <= burst_d;
      gap_cnt_q <= gap_cnt_d;
      wrap_q    <= wrap_d;
      done_q    <= done_d;
    end
  end

  // Tuple offset derives from counters that only move on a transfer, so the
  // presented tuple is stable while stalled. The packet count equals the
  // global packet index since it cannot wrap within one run.
  always_comb begin
    tuple_off = '0;
    unique case (mode_q)
      MODE_SEQ:  tuple_off = TUPLE_W'(pkt_cnt_q);
      MODE_WRAP: tuple_off = TUPLE_W'(wrap_q);
      MODE_LFSR: tuple_off = TUPLE_W'(lfsr_state);
      default:   tuple_off = '0;
    endcase
  end

  assign o_valid       = (state_q == ST_SEND);
  assign o_tuple       = base_q + tuple_off;
  assign o_raw_feature = o_valid ? feat_q : '0;
  assign o_busy        = (state_q != ST_IDLE);
  assign o_done        = done_q;
  assign o_pkt_cnt     = pkt_cnt_q;

endmodule
`default_nettype wire

// File: doc/tfe_stim_gen.md
Name: tfe_stim_gen

Overview:
- Synthesizable, parametrised packet-stimulus generator for the hash TFE.
- Drives 5-tuple plus raw-feature vectors into TFE_top's ip_tuple/ip_valid/i_raw_feature inputs, in place of hard-coded bench counters.
- Runs a programmed number of bursts separated by idle gaps, with selectable flow-ID modes.
- Honours downstream backpressure, so the same source serves simulation and on-FPGA soak tests.

Parameters:
- TUPLE_W, 104, width of flow 5-tuple.
- FEAT_W, 256, width of raw feature vector.
- CNT_W, 16, width of burst-length, gap-length, flow-modulus and packet counters.
- LFSR_SEED, 32'hACE1_2468, reset/start seed of the tuple LFSR; must be nonzero.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- cfg_start  in  1  one-cycle pulse; latches all cfg_* inputs and begins a run (honoured only in IDLE).
- cfg_abort  in  1  terminate the run; takes priority over all other events.
- cfg_mode  in  2  0 SEQ, 1 WRAP, 2 LFSR, 3 CONST.
- cfg_num_bursts  in  8  number of bursts.
- cfg_burst_len  in  CNT_W  packets per burst.
- cfg_gap_len  in  CNT_W  idle cycles between bursts.
- cfg_flow_mod  in  CNT_W  distinct flows in WRAP mode; value 0 is treated as 1.
- cfg_flow_base  in  TUPLE_W  base tuple.
- cfg_feature  in  FEAT_W  feature template applied to every packet.
- o_tuple  out  TUPLE_W  generated tuple.
- o_raw_feature  out  FEAT_W  generated feature.
- o_valid  out  1  packet valid.
- i_ready  in  1  downstream accept.
- o_busy  out  1  high from the cycle after cfg_start until DONE.
- o_done  out  1  one-cycle pulse at run end; not asserted on abort.
- o_pkt_cnt  out  CNT_W+8  handshakes in the current or last run; wraps modulo 2^(CNT_W+8).

Behaviour:
- Reset: state IDLE. o_valid, o_busy, o_done = 0. o_tuple, o_raw_feature, o_pkt_cnt = 0. LFSR = LFSR_SEED.
- Handshake: a transfer occurs when o_valid & i_ready.
  - While o_valid & !i_ready, o_tuple and o_raw_feature hold stable.
  - o_valid never deasserts without a transfer, except on abort or rst.
- FSM states: IDLE, SEND, GAP, DONE.
- IDLE:
  - On cfg_start: latch config, clear o_pkt_cnt, zero the burst and index counters, reload LFSR_SEED.
  - If num_bursts == 0 or burst_len == 0, go to DONE.
  - Otherwise go to SEND with the first packet presented: o_valid = 1 in cycle t+1 for cfg_start in cycle t.
- SEND, on each transfer:
  - pkt_cnt += 1, idx += 1, LFSR advances.
  - If idx reaches burst_len: burst += 1. If burst == num_bursts, go to DONE (o_valid low next cycle). Otherwise go to GAP if gap_len != 0, else stay in SEND with idx = 0.
  - Otherwise present the next packet in the next cycle; back-to-back transfers give 1 packet/cycle.
- GAP: o_valid = 0 for exactly gap_len cycles, then SEND with idx = 0.
- DONE: o_done = 1 for one cycle, o_busy drops in that cycle, then IDLE.
- Tuple generation, all additions modulo 2^TUPLE_W; gidx = global packet index within the run:
  - SEQ: base + gidx.
  - WRAP: base + (gidx mod flow_mod), implemented as a wrapping counter with no divider.
  - LFSR: base + zero-extended 32-bit LFSR state.
  - CONST: base.
- o_raw_feature = latched cfg_feature while o_valid; 0 otherwise.
- cfg_start while busy: ignored, config unchanged.
- cfg_abort in any state: next cycle IDLE, o_valid = 0, no o_done, o_pkt_cnt retains its value. Abort and start in the same cycle: abort wins, run not started.
- rst mid-run: identical to reset state next cycle.
- cfg_* inputs may change freely after the start cycle; only latched copies are used.

Decomposition:
- Package tfe_pkg:
  - TUPLE_W and FEAT_W defaults.
  - Mode constants MODE_SEQ/WRAP/LFSR/CONST.
  - FSM state encoding.
  - LFSR tap constant (x^32+x^22+x^2+x+1).
- Sub-module tfe_lfsr: 32-bit Galois LFSR with seed load and advance enable.
  - Shared later with the hash-collision stress bench.

Test Plan:
- SEQ, base=0, num_bursts=2, burst_len=10, gap=30, i_ready=1 -> tuples 0..9 in consecutive cycles, 30 idle cycles, then 10..19; o_done once; o_pkt_cnt=20.
- WRAP, base=0x100, flow_mod=3, 1 burst of 7 -> tuples 0x100,101,102,100,101,102,100; flow_mod=0 run -> all 0x100.
- Backpressure: SEQ, 1 burst of 5, i_ready toggles 1,0,0,1,... -> each tuple held while not ready, exactly 5 transfers, values 0..4, none dropped or duplicated.
- Boundaries: burst_len=0 or num_bursts=0 -> o_done two cycles after cfg_start, o_valid never high. gap=0 with 3x4 -> 12 back-to-back packets.
- Abort in burst 2 of 3 -> o_valid low next cycle, no o_done, o_pkt_cnt frozen. cfg_start during a run ignored. A new cfg_start afterwards restarts from base with the LFSR reseeded (identical LFSR sequence).
- Sync reset asserted mid-SEND -> all outputs at reset values on the next clock. Reset is not sampled between edges (checked by pulsing rst off-edge).
